acc_store_buffer: RTL and testbench

Read-side companion to the accumulator register: captures the accumulator output on a store strobe and delivers the captured values, in order, to a downstream consumer over a valid/ready handshake. A small FIFO decouples the datapath, which may store on consecutive cycles, from a consumer that may stall, such as a memory-write port or an output port. The block reports occupancy and flags stores lost to a full buffer through a sticky overflow bit.

---
 rtl/acc_store_buffer.sv | 78 +++++++
 tb/tb_acc_store_buffer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/acc_store_buffer.sv
// Store buffer behind the accumulator: captures ac_in on st_ac into a small FIFO
// and presents entries in order on a first-word fall-through valid/ready port.
module acc_store_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_ac,
  input  logic [DATA_WIDTH-1:0]      ac_in,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Status and head come only from registered state, so neither st_ac nor
  // out_ready has a combinational path to any output.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  assign pop  = out_valid & out_ready;
  // A full buffer still accepts a store when the head leaves on the same edge.
  assign push = st_ac & (!full | pop);
  assign drop = st_ac & full & !pop;

  // NOTE: the storage array is deliberately outside the reset domain; readers
  // never look at an entry before it has been written, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ac_in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of push/pop regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped store wins over a simultaneous clear so no loss goes unreported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_store_buffer.sv
// Directed bench for acc_store_buffer: a queue scoreboard models the FIFO, and
// every head, pop and status value is checked against it once per cycle.
module tb_acc_store_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_ac;
  logic [DW-1:0] ac_in;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          overflow;
  logic          clr_ovf;

  int            n_checks = 0;
  int            n_fails  = 0;
  logic [DW-1:0] sb [$];
  logic          m_ovf = 1'b0;

  acc_store_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_ac     (st_ac),
    .ac_in     (ac_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: inputs are applied just after a rising edge, the DUT is
  // compared with the model at the falling edge, then the model takes the edge.
  task automatic cycle(input logic st, input logic [DW-1:0] d, input logic rdy,
                       input logic clr, input string tag);
    logic m_pop, m_push, m_drop;
    st_ac = st; ac_in = d; out_ready = rdy; clr_ovf = clr;
    @(negedge clk);
    chk({tag, "_count"}, 32'(count), 32'(sb.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(sb.size() == DEPTH));
    chk({tag, "_valid"}, 32'(out_valid), 32'(sb.size() != 0));
    chk({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
    if (sb.size() != 0) chk({tag, "_head"}, 32'(out_data), 32'(sb[0]));
    m_pop  = rdy && (sb.size() != 0);
    m_push = st && ((sb.size() < DEPTH) || m_pop);
    m_drop = st && !m_push;
    if (m_pop)  void'(sb.pop_front());
    if (m_push) sb.push_back(d);
    if (m_drop)   m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; st_ac = 1'b0; ac_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_count", 32'(count), 0);
    chk("por_empty", 32'(empty), 1);
    chk("por_full",  32'(full), 0);
    chk("por_valid", 32'(out_valid), 0);
    chk("por_ovf",   32'(overflow), 0);
    rst = 1'b1;

    // Reset mid-run with three entries held, then a single store.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, "pre_rst");
    rst = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ovf",   32'(overflow), 0);
    sb.delete();
    m_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, "single_st");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "single_out");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "single_empty");

    // Fill and drain twice so both pointers wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(4 * r + i + 1), 1'b0, 1'b0, "fill");
      cycle(1'b0, 8'h00, 1'b0, 1'b0, "fill_full");
      chk("fill_full_flag", 32'(full), 1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      cycle(1'b0, 8'h00, 1'b0, 1'b0, "drain_done");
    end

    // Overflow: drop, drop with clear (set wins), clear alone, then drain.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, "ovf_fill");
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, "ovf_drop");
    cycle(1'b1, 8'hFE, 1'b0, 1'b1, "ovf_drop_clr");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr");
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "ovf_drain");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "ovf_done");

    // Full with a simultaneous push and pop.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, "fpp_fill");
    cycle(1'b1, 8'h14, 1'b1, 1'b0, "fpp_both");
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "fpp_drain");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "fpp_done");

    // Backpressure: head must hold while a second store lands behind it.
    cycle(1'b1, 8'h33, 1'b0, 1'b0, "bp_st33");
    cycle(1'b1, 8'h44, 1'b0, 1'b0, "bp_st44");
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, "bp_hold");
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "bp_drain");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "bp_done");

    // Streaming: one store and one pop per cycle, occupancy never above one.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, "stream");
      chk("stream_count_le1", 32'(count <= 3'd1), 1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "stream_last");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "stream_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
